// File: rtl/uart_pkg.sv
// Shared UART types: parity encodings and transmit FSM states.
// Used by both the transmit framer and the receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE   = 3'b000,
        PAR_ODD    = 3'b001,
        PAR_EVEN   = 3'b010,
        PAR_STICK0 = 3'b100,
        PAR_STICK1 = 3'b101
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_e;

    // Unlisted codes fall back to no parity.
    function automatic parity_e parity_decode(input logic [2:0] code);
        case (code)
            3'b001:  return PAR_ODD;
            3'b010:  return PAR_EVEN;
            3'b100:  return PAR_STICK0;
            3'b101:  return PAR_STICK1;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic parity_bit(input parity_e p, input logic x);
        case (p)
            PAR_ODD:    return ~x;
            PAR_EVEN:   return x;
            PAR_STICK1: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Character handshake between the TX FIFO read port and the framer.
interface uart_tx_framer_if #(
    parameter int MDW = 9
);
    logic [MDW-1:0] tx_data;
    logic           tx_valid;
    logic           tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Prescaler down-counter: one-cycle tick every prescale+1 enabled clocks.
module uart_baud_tick #(
    parameter int PRW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           load,
    input  logic [PRW-1:0] prescale,
    output logic           tick
);
    logic [PRW-1:0] cnt;

    assign tick = en & (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= prescale;
        end else if (en) begin
            if (cnt == '0)
                cnt <= prescale;
            else
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 5..MDW data bits LSB-first,
// optional parity, one or two stop bits.
import uart_pkg::*;

module uart_tx_framer #(
    parameter int MDW = 9,
    parameter int SC  = 8,
    parameter int PRW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PRW-1:0]      prescale,
    input  logic [3:0]          data_size,
    input  logic [2:0]          parity_type,
    input  logic                stop2,
    uart_tx_framer_if.slave     bus,
    output logic                tx,
    output logic                busy,
    output logic                done
);
    localparam int TW = $clog2(SC);

    tx_state_e      state;
    logic [MDW-1:0] shreg;
    logic [3:0]     nbits;
    logic [3:0]     bit_idx;
    parity_e        ptype;
    logic           two_stop;
    logic           par_acc;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic           accept;
    logic           bit_end;
    logic           par_next;

    function automatic logic [3:0] clamp_size(input logic [3:0] ds);
        if (ds < 4'd5)
            return 4'd5;
        if (ds > 4'(MDW))
            return 4'(MDW);
        return ds;
    endfunction

    assign bus.tx_ready = en & (state == IDLE);
    assign accept       = bus.tx_valid & bus.tx_ready;
    assign bit_end      = tick & (tick_cnt == TW'(SC - 1));
    assign par_next     = par_acc ^ shreg[0];

    uart_baud_tick #(
        .PRW(PRW)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (accept),
        .prescale(prescale),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            nbits    <= '0;
            bit_idx  <= '0;
            ptype    <= PAR_NONE;
            two_stop <= 1'b0;
            par_acc  <= 1'b0;
            tick_cnt <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && tick)
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            if (!en) begin
                // Abort: drop the snapshot and park the line.
                state <= IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            shreg    <= bus.tx_data;
                            nbits    <= clamp_size(data_size);
                            ptype    <= parity_decode(parity_type);
                            two_stop <= stop2;
                            par_acc  <= 1'b0;
                            bit_idx  <= '0;
                            tick_cnt <= '0;
                            state    <= START;
                            tx       <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            state <= DATA;
                            tx    <= shreg[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shreg   <= shreg >> 1;
                            par_acc <= par_next;
                            if (bit_idx == nbits - 4'd1) begin
                                if (ptype != PAR_NONE) begin
                                    state <= PARITY;
                                    tx    <= parity_bit(ptype, par_next);
                                end else begin
                                    state <= STOP1;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                tx      <= shreg[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state <= STOP1;
                            tx    <= 1'b1;
                        end
                    end
                    STOP1: begin
                        if (bit_end) begin
                            if (two_stop) begin
                                state <= STOP2;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    STOP2: begin
                        if (bit_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
